// File: rtl/resp_join_cut.sv
// resp_join_cut: joins per-cluster Ara response streams into one registered response toward CVA6.
// Optional feature macro RESP_JOIN_ID_CHECK_EN adds a sticky cross-cluster trans-ID mismatch flag.
module resp_join_cut #(
  parameter int NrClusters   = 2,
  parameter int DataWidth    = 64,
  parameter int TransIdWidth = 3,
  parameter int FifoDepth    = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NrClusters-1:0]              resp_valid_i,
  output logic [NrClusters-1:0]              resp_ready_o,
  input  logic [NrClusters*DataWidth-1:0]    resp_result_i,
  input  logic [NrClusters*TransIdWidth-1:0] resp_trans_id_i,
  input  logic [NrClusters-1:0]              resp_error_i,
  input  logic [NrClusters*5-1:0]            resp_fflags_i,
  output logic                               resp_valid_o,
  input  logic                               resp_ready_i,
  output logic [DataWidth-1:0]               resp_result_o,
  output logic [TransIdWidth-1:0]            resp_trans_id_o,
  output logic                               resp_error_o,
  output logic [4:0]                         resp_fflags_o,
  output logic                               id_mismatch_o
);
  localparam int PtrWidth   = $clog2(FifoDepth) + 1;
  localparam int IdxWidth   = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int MemDepth   = 1 << IdxWidth;
  localparam int EntryWidth = DataWidth + TransIdWidth + 6;
  localparam logic [PtrWidth-1:0] LastIdx = PtrWidth'(FifoDepth - 1);
  localparam logic [PtrWidth-1:0] FullCnt = PtrWidth'(FifoDepth);
  localparam logic [PtrWidth-1:0] PtrZero = PtrWidth'(0);
  localparam logic [PtrWidth-1:0] PtrOne  = PtrWidth'(1);

  // entry layout: {error, fflags, trans_id, result}
  logic [EntryWidth-1:0]   mem_r    [NrClusters][MemDepth];
  logic [PtrWidth-1:0]     rd_ptr_r [NrClusters];
  logic [PtrWidth-1:0]     wr_ptr_r [NrClusters];
  logic [PtrWidth-1:0]     cnt_r    [NrClusters];
  logic [EntryWidth-1:0]   head_s   [NrClusters];
  logic [EntryWidth-1:0]   entry_s  [NrClusters];
  logic [NrClusters-1:0]   full_s;
  logic [NrClusters-1:0]   empty_s;
  logic [NrClusters-1:0]   push_s;
  logic                    all_avail_s;
  logic                    load_s;
  logic                    merged_error_s;
  logic [4:0]              merged_fflags_s;
  logic                    valid_r;
  logic [DataWidth-1:0]    result_r;
  logic [TransIdWidth-1:0] trans_id_r;
  logic                    error_r;
  logic [4:0]              fflags_r;

  // Per-cluster FIFO status, heads and incoming entries
  always_comb begin
    for (int i = 0; i < NrClusters; i++) begin
      full_s[i]  = (cnt_r[i] == FullCnt);
      empty_s[i] = (cnt_r[i] == PtrZero);
      push_s[i]  = resp_valid_i[i] && !full_s[i];
      head_s[i]  = mem_r[i][rd_ptr_r[i][IdxWidth-1:0]];
      entry_s[i] = {resp_error_i[i], resp_fflags_i[i*5 +: 5],
                    resp_trans_id_i[i*TransIdWidth +: TransIdWidth],
                    resp_result_i[i*DataWidth +: DataWidth]};
    end
  end

  // Join condition and merge of the FIFO heads
  always_comb begin
    all_avail_s     = &(~empty_s);
    load_s          = all_avail_s && (!valid_r || resp_ready_i);
    merged_error_s  = 1'b0;
    merged_fflags_s = 5'b00000;
    for (int i = 0; i < NrClusters; i++) begin
      merged_error_s  = merged_error_s | head_s[i][EntryWidth-1];
      merged_fflags_s = merged_fflags_s | head_s[i][DataWidth+TransIdWidth +: 5];
    end
  end

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NrClusters; i++) begin
      if (push_s[i]) begin
        mem_r[i][wr_ptr_r[i][IdxWidth-1:0]] <= entry_s[i];
      end
    end
  end

  // FIFO pointers and occupancy; every FIFO pops together on an output load
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NrClusters; i++) begin
        rd_ptr_r[i] <= PtrZero;
        wr_ptr_r[i] <= PtrZero;
        cnt_r[i]    <= PtrZero;
      end
    end else begin
      for (int i = 0; i < NrClusters; i++) begin
        if (push_s[i]) begin
          wr_ptr_r[i] <= (wr_ptr_r[i] == LastIdx) ? PtrZero : wr_ptr_r[i] + PtrOne;
        end
        if (load_s) begin
          rd_ptr_r[i] <= (rd_ptr_r[i] == LastIdx) ? PtrZero : rd_ptr_r[i] + PtrOne;
        end
        case ({push_s[i], load_s})
          2'b10:   cnt_r[i] <= cnt_r[i] + PtrOne;
          2'b01:   cnt_r[i] <= cnt_r[i] - PtrOne;
          default: cnt_r[i] <= cnt_r[i];
        endcase
      end
    end
  end

  // Output cut register; payload only changes on a load so it holds under backpressure
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_r    <= 1'b0;
      result_r   <= {DataWidth{1'b0}};
      trans_id_r <= {TransIdWidth{1'b0}};
      error_r    <= 1'b0;
      fflags_r   <= 5'b00000;
    end else if (load_s) begin
      valid_r    <= 1'b1;
      result_r   <= head_s[0][DataWidth-1:0];
      trans_id_r <= head_s[0][DataWidth +: TransIdWidth];
      error_r    <= merged_error_s;
      fflags_r   <= merged_fflags_s;
    end else if (resp_ready_i) begin
      valid_r    <= 1'b0;
    end
  end

`ifdef RESP_JOIN_ID_CHECK_EN
  logic mismatch_s;
  logic id_mismatch_r;

  // Any head trans-ID differing from cluster 0's
  always_comb begin
    mismatch_s = 1'b0;
    for (int i = 1; i < NrClusters; i++) begin
      if (head_s[i][DataWidth +: TransIdWidth] != head_s[0][DataWidth +: TransIdWidth]) begin
        mismatch_s = 1'b1;
      end else begin
        mismatch_s = mismatch_s;
      end
    end
  end

  // Sticky mismatch flag, cleared only by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_mismatch_r <= 1'b0;
    end else if (load_s && mismatch_s) begin
      id_mismatch_r <= 1'b1;
    end
  end

  assign id_mismatch_o = id_mismatch_r;

`ifndef SYNTHESIS
  resp_join_cut_id_chk u_id_chk (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load     (load_s),
    .mismatch (mismatch_s)
  );
`endif
`else
  assign id_mismatch_o = 1'b0;
`endif

  assign resp_ready_o    = ~full_s;
  assign resp_valid_o    = valid_r;
  assign resp_result_o   = result_r;
  assign resp_trans_id_o = trans_id_r;
  assign resp_error_o    = error_r;
  assign resp_fflags_o   = fflags_r;

endmodule

`ifdef RESP_JOIN_ID_CHECK_EN
`ifndef SYNTHESIS
// Simulation checker: flags any merge of responses carrying different trans-IDs.
module resp_join_cut_id_chk (
  input logic clk_i,
  input logic rst_ni,
  input logic load,
  input logic mismatch
);
  // Mismatch must never accompany a load
  always @(posedge clk_i) begin
    if (rst_ni) begin
      id_match_a: assert (!(load && mismatch))
        else $error("resp_join_cut: trans-ID mismatch across clusters");
    end
  end
endmodule
`endif
`endif

// File: tb/tb_resp_join_cut.sv
// Self-checking bench for resp_join_cut: directed test-plan scenarios plus randomized traffic
// checked every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_resp_join_cut;
  localparam int NC = 2;
  localparam int DW = 64;
  localparam int TW = 3;
  localparam int FD = 2;
`ifdef RESP_JOIN_ID_CHECK_EN
  localparam logic IdChk = 1'b1;
`else
  localparam logic IdChk = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] res;
    logic [TW-1:0] id;
    logic          err;
    logic [4:0]    ff;
  } ent_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NC-1:0]      resp_valid_i = '0;
  logic [NC-1:0]      resp_ready_o;
  logic [NC*DW-1:0]   resp_result_i = '0;
  logic [NC*TW-1:0]   resp_trans_id_i = '0;
  logic [NC-1:0]      resp_error_i = '0;
  logic [NC*5-1:0]    resp_fflags_i = '0;
  logic               resp_valid_o;
  logic               resp_ready_i = 1'b0;
  logic [DW-1:0]      resp_result_o;
  logic [TW-1:0]      resp_trans_id_o;
  logic               resp_error_o;
  logic [4:0]         resp_fflags_o;
  logic               id_mismatch_o;

  resp_join_cut #(.NrClusters(NC), .DataWidth(DW), .TransIdWidth(TW), .FifoDepth(FD)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .resp_valid_i(resp_valid_i), .resp_ready_o(resp_ready_o),
    .resp_result_i(resp_result_i), .resp_trans_id_i(resp_trans_id_i),
    .resp_error_i(resp_error_i), .resp_fflags_i(resp_fflags_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_result_o(resp_result_o), .resp_trans_id_o(resp_trans_id_o),
    .resp_error_o(resp_error_o), .resp_fflags_o(resp_fflags_o),
    .id_mismatch_o(id_mismatch_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  ent_t       mq [NC][$];
  logic       m_valid = 1'b0;
  ent_t       m_pay = '0;
  logic       m_mis = 1'b0;
  int         n_acc = 0;
  int         pc [NC];

  // per-cycle drive and observation
  logic [NC-1:0] d_valid = '0;
  ent_t          d_ent [NC];
  logic          d_ready = 1'b0;
  logic          o_valid;
  logic [DW-1:0] o_res;
  logic [TW-1:0] o_id;
  logic          o_err;
  logic [4:0]    o_ff;
  logic [NC-1:0] o_ready;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_push(input int i, input logic [DW-1:0] res, input logic [TW-1:0] id,
                          input logic err, input logic [4:0] ff);
    d_valid[i] = 1'b1;
    d_ent[i]   = '{res: res, id: id, err: err, ff: ff};
  endtask

  task automatic idle();
    d_valid = '0;
  endtask

  // One clock cycle: check DUT against model, drive this cycle's inputs, advance the model.
  task automatic cycle();
    int   pre_sz [NC];
    logic avail;
    logic mis_now;
    ent_t mg;
    @(negedge clk);
    o_valid = resp_valid_o; o_res = resp_result_o; o_id = resp_trans_id_o;
    o_err = resp_error_o; o_ff = resp_fflags_o; o_ready = resp_ready_o;
    check_eq("valid", 64'(o_valid), 64'(m_valid));
    if (m_valid) begin
      check_eq("result", o_res, m_pay.res);
      check_eq("trans_id", 64'(o_id), 64'(m_pay.id));
      check_eq("error", 64'(o_err), 64'(m_pay.err));
      check_eq("fflags", 64'(o_ff), 64'(m_pay.ff));
    end
    for (int i = 0; i < NC; i++) begin
      pre_sz[i] = mq[i].size();
      check_eq("ready_o", 64'(o_ready[i]), 64'(pre_sz[i] < FD));
    end
    check_eq("id_mismatch", 64'(id_mismatch_o), 64'(m_mis));
    for (int i = 0; i < NC; i++) begin
      resp_valid_i[i] = d_valid[i];
      resp_result_i[i*DW +: DW] = d_ent[i].res;
      resp_trans_id_i[i*TW +: TW] = d_ent[i].id;
      resp_error_i[i] = d_ent[i].err;
      resp_fflags_i[i*5 +: 5] = d_ent[i].ff;
    end
    resp_ready_i = d_ready;
    if (m_valid && d_ready) n_acc++;
    avail = 1'b1;
    for (int i = 0; i < NC; i++) if (pre_sz[i] == 0) avail = 1'b0;
    if (avail && (!m_valid || d_ready)) begin
      mg = mq[0][0];
      mg.err = 1'b0;
      mg.ff = 5'b00000;
      mis_now = 1'b0;
      for (int i = 0; i < NC; i++) begin
        mg.err = mg.err | mq[i][0].err;
        mg.ff = mg.ff | mq[i][0].ff;
        if (mq[i][0].id != mq[0][0].id) mis_now = 1'b1;
        void'(mq[i].pop_front());
      end
      m_pay = mg;
      m_valid = 1'b1;
      if (IdChk) m_mis = m_mis | mis_now;
    end else if (d_ready) begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < NC; i++) begin
      if (d_valid[i] && pre_sz[i] < FD) begin
        mq[i].push_back(d_ent[i]);
        pc[i]++;
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NC; i++) mq[i].delete();
    m_valid = 1'b0;
    m_pay = '0;
    m_mis = 1'b0;
  endtask

  // Assert reset right after the current drive point, check reset outputs, release on a negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    resp_valid_i = '0;
    #1;
    check_eq("rst_valid", 64'(resp_valid_o), 64'd0);
    check_eq("rst_result", resp_result_o, 64'd0);
    check_eq("rst_trans_id", 64'(resp_trans_id_o), 64'd0);
    check_eq("rst_error", 64'(resp_error_o), 64'd0);
    check_eq("rst_fflags", 64'(resp_fflags_o), 64'd0);
    check_eq("rst_mismatch", 64'(id_mismatch_o), 64'd0);
    check_eq("rst_ready_o", 64'(resp_ready_o), 64'(2'b11));
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NC; i++) begin
      d_ent[i] = '0;
      pc[i] = 0;
    end
    @(negedge clk);
    do_reset();

    // lockstep: valid exactly in cycle 2
    d_ready = 1'b1;
    set_push(0, 64'hA5, 3'd3, 1'b0, 5'b00000);
    set_push(1, 64'hA5, 3'd3, 1'b0, 5'b00000);
    cycle();
    idle();
    cycle();
    check_eq("lock_c1_valid", 64'(o_valid), 64'd0);
    cycle();
    check_eq("lock_c2_valid", 64'(o_valid), 64'd1);
    check_eq("lock_c2_result", o_res, 64'hA5);
    check_eq("lock_c2_id", 64'(o_id), 64'd3);
    check_eq("lock_c2_err", 64'(o_err), 64'd0);
    cycle();

    // skew: cluster 1 arrives 5 cycles late, output first in cycle 7
    for (int t = 0; t < 9; t++) begin
      idle();
      if (t == 0) set_push(0, 64'h11, 3'd1, 1'b0, 5'b00000);
      if (t == 5) set_push(1, 64'h22, 3'd1, 1'b0, 5'b00000);
      cycle();
      if (t < 7) check_eq("skew_early_valid", 64'(o_valid), 64'd0);
      if (t == 7) check_eq("skew_c7_valid", 64'(o_valid), 64'd1);
      if (t == 7) check_eq("skew_c7_result", o_res, 64'h11);
    end

    // backpressure: three responses per cluster with ready low, then drain
    d_ready = 1'b0;
    for (int t = 0; t < 6; t++) begin
      idle();
      if (t < 3) begin
        set_push(0, 64'(32'h100 + t), 3'(t), 1'b0, 5'b00000);
        set_push(1, 64'(32'h200 + t), 3'(t), 1'b0, 5'b00000);
      end
      cycle();
      if (t >= 3) begin
        check_eq("bp_ready_low", 64'(o_ready), 64'd0);
        check_eq("bp_hold_valid", 64'(o_valid), 64'd1);
        check_eq("bp_hold_result", o_res, 64'h100);
      end
    end
    d_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      cycle();
      check_eq("bp_drain_valid", 64'(o_valid), 64'(t < 3));
      if (t < 3) check_eq("bp_drain_result", o_res, 64'(32'h100 + t));
    end

    // merge of error and fflags
    set_push(0, 64'h5555, 3'd2, 1'b0, 5'b00001);
    set_push(1, 64'hAAAA, 3'd2, 1'b1, 5'b10000);
    cycle();
    idle();
    cycle();
    cycle();
    check_eq("merge_err", 64'(o_err), 64'd1);
    check_eq("merge_fflags", 64'(o_ff), 64'h11);
    check_eq("merge_result", o_res, 64'h5555);
    cycle();

    // trans-ID mismatch: sticky when the check is built in, otherwise always 0
    set_push(0, 64'h2, 3'd2, 1'b0, 5'b00000);
    set_push(1, 64'h4, 3'd4, 1'b0, 5'b00000);
    cycle();
    idle();
    cycle();
    check_eq("mis_before_load", 64'(id_mismatch_o), 64'd0);
    cycle();
    check_eq("mis_after_load", 64'(id_mismatch_o), 64'(IdChk));
    set_push(0, 64'h5, 3'd5, 1'b0, 5'b00000);
    set_push(1, 64'h5, 3'd5, 1'b0, 5'b00000);
    cycle();
    idle();
    for (int t = 0; t < 3; t++) cycle();
    check_eq("mis_sticky", 64'(id_mismatch_o), 64'(IdChk));

    // reset mid-operation with valid_q=1 and one entry in cluster 0
    d_ready = 1'b0;
    set_push(0, 64'h77, 3'd6, 1'b0, 5'b00000);
    set_push(1, 64'h77, 3'd6, 1'b0, 5'b00000);
    cycle();
    idle();
    set_push(0, 64'h78, 3'd7, 1'b0, 5'b00000);
    cycle();
    idle();
    cycle();
    check_eq("pre_rst_valid", 64'(o_valid), 64'd1);
    do_reset();
    d_ready = 1'b1;
    n_acc = 0;
    set_push(0, 64'h99, 3'd1, 1'b0, 5'b00000);
    set_push(1, 64'h99, 3'd1, 1'b0, 5'b00000);
    cycle();
    idle();
    for (int t = 0; t < 6; t++) cycle();
    check_eq("post_rst_count", 64'(n_acc), 64'd1);

    // randomized traffic with per-cluster in-order trans-IDs
    for (int i = 0; i < NC; i++) pc[i] = 0;
    for (int t = 0; t < 800; t++) begin
      for (int i = 0; i < NC; i++) begin
        d_valid[i] = ($urandom_range(0, 9) < 6);
        d_ent[i] = '{res: {$urandom, $urandom}, id: 3'(pc[i]),
                     err: ($urandom_range(0, 7) == 0), ff: 5'($urandom)};
      end
      d_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    idle();
    d_ready = 1'b1;
    for (int t = 0; t < 8; t++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
